// File: rtl/complex_matrix_packer.sv
// Collects one complex element per input beat into a MAT_HEIGHT x MAT_WIDTH matrix
// and emits it as a single wide beat, flagging malformed framing on m_axis_tuser.
module complex_matrix_packer #(
  parameter int MAT_WIDTH    = 4,
  parameter int MAT_HEIGHT   = 4,
  parameter int ELEMENT_SIZE = 32
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [ELEMENT_SIZE-1:0]                    s_axis_tdata,
  input  logic                                       s_axis_tvalid,
  output logic                                       s_axis_tready,
  input  logic                                       s_axis_tlast,
  input  logic                                       s_axis_tuser,
  output logic [MAT_WIDTH*MAT_HEIGHT*ELEMENT_SIZE-1:0] m_axis_tdata,
  output logic                                       m_axis_tvalid,
  input  logic                                       m_axis_tready,
  output logic                                       m_axis_tlast,
  output logic                                       m_axis_tuser
);
  localparam int N  = MAT_WIDTH * MAT_HEIGHT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = N * ELEMENT_SIZE;

  typedef enum logic [1:0] {INIT, FILL, HOLD} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d, slot;
  logic [DW-1:0]   data_q, data_d;
  logic            err_q, err_d;
  logic            tuser_q, tuser_d;
  logic            resync, done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      idx_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      tuser_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      err_q   <= err_d;
      tuser_q <= tuser_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    err_d   = err_q;
    tuser_d = tuser_q;
    slot    = idx_q;
    resync  = 1'b0;
    done    = 1'b0;
    case (state_q)
      INIT: state_d = FILL;
      FILL: begin
        if (s_axis_tvalid) begin
          // A start marker mid-frame drops the partial matrix and restarts at slot 0.
          resync = s_axis_tuser && (idx_q != '0);
          if (resync) begin
            data_d = '0;
            slot   = '0;
            err_d  = 1'b1;
          end
          for (int k = 0; k < N; k++) begin
            if (slot == IW'(k)) data_d[k*ELEMENT_SIZE +: ELEMENT_SIZE] = s_axis_tdata;
          end
          done = (slot == IW'(N-1)) || s_axis_tlast;
          if (done) begin
            state_d = HOLD;
            idx_d   = slot;
            tuser_d = err_d || !s_axis_tlast || (slot != IW'(N-1));
          end else begin
            idx_d = slot + 1'b1;
          end
        end
      end
      HOLD: begin
        if (m_axis_tready) begin
          state_d = FILL;
          data_d  = '0;
          idx_d   = '0;
          err_d   = 1'b0;
          tuser_d = 1'b0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign s_axis_tready = (state_q == FILL);
  assign m_axis_tvalid = (state_q == HOLD);
  assign m_axis_tlast  = (state_q == HOLD);
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tdata  = data_q;

endmodule
